// File: rtl/ula_serial_pkg.sv
// ula_serial_pkg: shared opcode and FSM state definitions for the bit-serial ALU and its benches
package ula_serial_pkg;
  localparam logic [2:0] FN_ADD   = 3'b000;
  localparam logic [2:0] FN_SUB   = 3'b001;
  localparam logic [2:0] FN_AND   = 3'b010;
  localparam logic [2:0] FN_OR    = 3'b011;
  localparam logic [2:0] FN_XNOR  = 3'b100;
  localparam logic [2:0] FN_NOTA  = 3'b101;
  localparam logic [2:0] FN_PASSA = 3'b110;
  localparam logic [2:0] FN_NOTB  = 3'b111;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/ula_serial_if.sv
// ula_serial_if: request/result bundle; master drives start/func/a/b, slave returns busy/done/r/cout/comp
interface ula_serial_if #(parameter int N = 8);
  logic         start;
  logic [2:0]   func;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] r;
  logic         cout;
  logic         comp;
  modport master (output start, func, a, b, input busy, done, r, cout, comp);
  modport slave  (input start, func, a, b, output busy, done, r, cout, comp);
endinterface

// File: rtl/ula_serial_bit_slice.sv
// ula_serial_bit_slice: one-bit ALU slice; ports an/bn operand bits, func opcode, cin_soma/cin_comp chain inputs, rn result bit, cout_soma/cout_comp chain outputs
module ula_serial_bit_slice
  import ula_serial_pkg::*;
(
  input  logic       an,
  input  logic       bn,
  input  logic [2:0] func,
  input  logic       cin_soma,
  input  logic       cin_comp,
  output logic       rn,
  output logic       cout_soma,
  output logic       cout_comp
);
  logic arith;
  assign arith = func == FN_ADD || func == FN_SUB;
  assign rn = arith ? an ^ bn ^ cin_soma :
              func == FN_AND   ? an & bn :
              func == FN_OR    ? an | bn :
              func == FN_XNOR  ? ~(an ^ bn) :
              func == FN_NOTA  ? ~an :
              func == FN_PASSA ? an : ~bn;
  // add propagates a carry, sub propagates a borrow, logic ops keep the chain at 0
  assign cout_soma = func == FN_ADD ? (an & bn) | (cin_soma & (an ^ bn)) :
                     func == FN_SUB ? (~an & bn) | (cin_soma & ~(an ^ bn)) : 1'b0;
  // equality chain: stays 1 only while every processed bit pair matches
  assign cout_comp = cin_comp & ~(an ^ bn);
endmodule

// File: rtl/ula_serial.sv
// ula_serial: bit-serial ALU, LSB first through one slice; ports clk, rst_n (async active-low), bus (slave: start/func/a/b in, busy/done/r/cout/comp out)
module ula_serial
  import ula_serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ula_serial_if.slave  bus
);
  localparam int CW = $clog2(N);
  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [2:0]    f_reg;
  logic [N-2:0]  acc;
  logic [CW-1:0] cnt;
  logic          cy;
  logic          cp;
  logic          rn;
  logic          co_s;
  logic          co_c;
  logic          last;
  logic [N-1:0]  nxt;
  assign last = cnt == CW'(N - 1);
  // result bits collected so far plus the bit being produced this cycle
  assign nxt = {rn, acc};
  ula_serial_bit_slice u_slice (
    .an        (a_reg[0]),
    .bn        (b_reg[0]),
    .func      (f_reg),
    .cin_soma  (cy),
    .cin_comp  (cp),
    .rn        (rn),
    .cout_soma (co_s),
    .cout_comp (co_c)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      f_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      cy       <= 1'b0;
      cp       <= 1'b1;
      bus.r    <= '0;
      bus.cout <= 1'b0;
      bus.comp <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_reg    <= bus.a;
          b_reg    <= bus.b;
          f_reg    <= bus.func;
          cnt      <= '0;
          cy       <= 1'b0;
          cp       <= 1'b1;
          bus.busy <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          acc   <= nxt[N-1:1];
          cy    <= co_s;
          cp    <= co_c;
          // counter parks at N-1 on the final bit so it never wraps
          cnt   <= last ? cnt : cnt + 1'b1;
          if (last) begin
            bus.r    <= nxt;
            bus.cout <= co_s;
            bus.comp <= co_c;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_serial.sv
// tb_ula_serial: scoreboard bench for ula_serial at N=8 (directed) and N=4 (exhaustive)
module tb_ula_serial;
  import ula_serial_pkg::*;
  typedef struct packed {logic [7:0] r; logic cout; logic comp;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int pushes8 = 0;
  int pushes4 = 0;
  int dones8 = 0;
  int dones4 = 0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t last8 = '0;
  exp_t e8;
  exp_t e4;
  ula_serial_if #(.N(8)) b8 ();
  ula_serial_if #(.N(4)) b4 ();
  ula_serial #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  ula_serial #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  always #5 clk = ~clk;

  function automatic exp_t model(input int n, input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0] s;
    logic [7:0] m;
    m = 8'((9'd1 << n) - 9'd1);
    e.cout = 1'b0;
    case (f)
      FN_ADD:   begin s = {1'b0, x} + {1'b0, y}; e.cout = s[n]; end
      FN_SUB:   begin s = {1'b0, x} - {1'b0, y}; e.cout = x < y; end
      FN_AND:   s = {1'b0, x & y};
      FN_OR:    s = {1'b0, x | y};
      FN_XNOR:  s = {1'b0, ~(x ^ y)};
      FN_NOTA:  s = {1'b0, ~x};
      FN_PASSA: s = {1'b0, x};
      default:  s = {1'b0, ~y};
    endcase
    e.r = s[7:0] & m;
    e.comp = x == y;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && b8.done) begin
    dones8++;
    checks++;
    assert (q8.size() != 0) else begin
      errors++;
      $error("FAIL spurious_done8 got done=1 expected no pending op");
    end
    if (q8.size() != 0) begin
      e8 = q8.pop_front();
      checks++;
      assert ({b8.r, b8.cout, b8.comp} === {e8.r, e8.cout, e8.comp}) else begin
        errors++;
        $error("FAIL result8 got r=%h cout=%b comp=%b expected r=%h cout=%b comp=%b",
               b8.r, b8.cout, b8.comp, e8.r, e8.cout, e8.comp);
      end
    end
  end

  always @(negedge clk) if (rst_n && b4.done) begin
    dones4++;
    checks++;
    assert (q4.size() != 0) else begin
      errors++;
      $error("FAIL spurious_done4 got done=1 expected no pending op");
    end
    if (q4.size() != 0) begin
      e4 = q4.pop_front();
      checks++;
      assert ({4'h0, b4.r, b4.cout, b4.comp} === {e4.r, e4.cout, e4.comp}) else begin
        errors++;
        $error("FAIL result4 got r=%h cout=%b comp=%b expected r=%h cout=%b comp=%b",
               b4.r, b4.cout, b4.comp, e4.r[3:0], e4.cout, e4.comp);
      end
    end
  end

  task automatic op8(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y, input bit poke);
    exp_t e;
    e = model(8, f, x, y);
    @(negedge clk);
    b8.start = 1'b1; b8.func = f; b8.a = x; b8.b = y;
    q8.push_back(e); pushes8++;
    @(posedge clk); #1;
    b8.start = 1'b0; b8.func = ~f; b8.a = ~x; b8.b = y ^ 8'h5A;
    chk("busy8", 32'(b8.busy), 32'd1);
    chk("hold8", 32'({b8.r, b8.cout, b8.comp}), 32'({last8.r, last8.cout, last8.comp}));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      b8.start = poke && i < 7;
    end
    @(negedge clk);
    chk("done8_latency", 32'(b8.done), 32'd1);
    chk("busy8_clear", 32'(b8.busy), 32'd0);
    b8.start = 1'b0;
    last8 = e;
    @(posedge clk); #1;
  endtask

  task automatic op4(input logic [2:0] f, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    b4.start = 1'b1; b4.func = f; b4.a = x; b4.b = y;
    q4.push_back(model(4, f, {4'h0, x}, {4'h0, y})); pushes4++;
    @(posedge clk); #1;
    b4.start = 1'b0; b4.a = ~x; b4.b = ~y;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("done4_latency", 32'(b4.done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    bit got;
    logic [7:0] ca[3] = '{8'h9C, 8'h41, 8'h80};
    logic [7:0] cb[3] = '{8'h27, 8'h41, 8'h81};
    logic [2:0] cf[3] = '{FN_ADD, FN_SUB, FN_SUB};
    b8.start = 0; b8.func = 0; b8.a = 0; b8.b = 0;
    b4.start = 0; b4.func = 0; b4.a = 0; b4.b = 0;
    #2;
    chk("rst_busy", 32'(b8.busy), 32'd0);
    chk("rst_done", 32'(b8.done), 32'd0);
    chk("rst_r", 32'(b8.r), 32'd0);
    chk("rst_cout_comp", 32'({b8.cout, b8.comp}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    op8(FN_ADD, 8'hFF, 8'h01, 1'b0);
    op8(FN_SUB, 8'h05, 8'h07, 1'b1);
    op8(FN_SUB, 8'h07, 8'h05, 1'b0);
    op8(FN_AND, 8'hF0, 8'h3C, 1'b1);
    op8(FN_NOTB, 8'h00, 8'h3C, 1'b0);
    op8(FN_XNOR, 8'hAA, 8'hAA, 1'b0);
    op8(FN_OR, 8'h12, 8'h81, 1'b0);
    op8(FN_NOTA, 8'h5A, 8'h00, 1'b0);
    op8(FN_PASSA, 8'hC3, 8'h77, 1'b0);
    op8(FN_ADD, 8'h80, 8'h80, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 32'(b8.busy), 32'd0);
      chk("idle_hold", 32'({b8.r, b8.cout, b8.comp, b8.done}), 32'({last8.r, last8.cout, last8.comp, 1'b0}));
    end
    // abort an operation with reset during its third shift cycle
    @(negedge clk);
    b8.start = 1'b1; b8.func = FN_ADD; b8.a = 8'h33; b8.b = 8'h44;
    @(posedge clk); #1; b8.start = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(b8.busy), 32'd0);
    chk("abort_r", 32'(b8.r), 32'd0);
    chk("abort_cout_comp_done", 32'({b8.cout, b8.comp, b8.done}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    last8 = '0;
    repeat (11) @(negedge clk);
    chk("abort_no_done", 32'(dones8), 32'(pushes8));
    op8(FN_ADD, 8'h12, 8'h34, 1'b0);
    // start held high; operands change while each operation runs
    @(negedge clk);
    b8.start = 1'b1; b8.func = cf[0]; b8.a = ca[0]; b8.b = cb[0];
    q8.push_back(model(8, cf[0], ca[0], cb[0])); pushes8++;
    for (int i = 0; i < 3; i++) begin
      c = 0;
      do begin @(posedge clk); #1; c++; end while (!b8.busy && c < 5);
      chk("cont_accept", 32'(b8.busy), 32'd1);
      b8.a = 8'hEE; b8.b = 8'h11; b8.func = FN_OR;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = b8.done; end
      chk("cont_done", 32'(got), 32'd1);
      if (i < 2) begin
        b8.func = cf[i+1]; b8.a = ca[i+1]; b8.b = cb[i+1];
        q8.push_back(model(8, cf[i+1], ca[i+1], cb[i+1])); pushes8++;
      end else b8.start = 1'b0;
    end
    repeat (12) @(negedge clk);
    chk("cont_count", 32'(dones8), 32'(pushes8));
    for (int f = 0; f < 8; f++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op4(3'(f), 4'(x), 4'(y));
    repeat (4) @(negedge clk);
    chk("sweep_count", 32'(dones4), 32'd2048);
    chk("q8_empty", 32'(q8.size()), 32'd0);
    chk("q4_empty", 32'(q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
